tausworthe_gen: RTL and testbench
=================================

# tausworthe_gen

Parametrised Tausworthe pseudo-random generator: a WIDTH-bit Fibonacci LFSR with configurable feedback taps, a runtime seed load with all-zero lock-up protection, and a serial bit output. It also packs WORD_BITS consecutive bits into words and delivers them over a valid/ready interface with backpressure. It replaces the fixed 8-bit `psp` generator in the tausworthe stimulus path, and its defaults reproduce `psp`'s bit stream.

## Interface
- WIDTH, 8: LFSR length in bits; minimum 2.
- TAPS, 8'b10111000: feedback mask, WIDTH bits. Bit i set means state[i] enters the feedback parity. TAPS[WIDTH-1] must be 1.
- RESET_VALUE, 8'b10101010: state after reset, WIDTH bits. Must be non-zero.
- WORD_BITS, 8: bits per output word; minimum 1.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance request.
- load  in  1  seed load strobe; has priority over en.
- seed  in  WIDTH  seed value, sampled when load=1.
- out  out  1  serial output, equal to state[WIDTH-1].
- word_data  out  WORD_BITS  packed word; the first generated bit is in the MSB.
- word_valid  out  1  word_data holds an unconsumed word.
- word_ready  in  1  consumer accepts the word on the current edge.
- seed_fixed  out  1  one-cycle pulse: the last load carried seed==0 and was replaced by RESET_VALUE.

## Operation
- Reset (rst=1 at an edge) sets:
  - state=RESET_VALUE, so out=RESET_VALUE[WIDTH-1];
  - bit count=0 and shift register=0;
  - word_data=0, word_valid=0, seed_fixed=0.
- rst overrides load, en and word_ready.
- Feedback fb = XOR-reduce(state & TAPS). Next state = {state[WIDTH-2:0], fb}, a left shift.
- adv = en & ~load & (~word_valid | word_ready).
- On adv:
  - out (the current MSB) is shifted into the word shift register;
  - the state advances;
  - the bit count increments.
- Word completion: when adv occurs with count==WORD_BITS-1:
  - word_data <= {shreg[WORD_BITS-2:0], out};
  - word_valid <= 1;
  - count <= 0.
- Handshake:
  - A word is consumed on an edge with word_valid & word_ready. word_valid clears unless a new word completes on the same edge, in which case it stays 1 with the new data.
  - word_data is stable while word_valid=1 and word_ready=0.
  - While word_valid=1 and word_ready=0, adv=0: state, out and count freeze.
- Load (load=1, rst=0):
  - state <= (seed==0) ? RESET_VALUE : seed;
  - seed_fixed <= (seed==0);
  - count and shreg are cleared, discarding any partial word;
  - a pending word (word_valid=1) is kept, and it can still be consumed on the same edge.
- seed_fixed is 0 on every edge that is not a zero-seed load.
- en=0 holds all state; the handshake still completes.

## Timing
- out is combinational from the state register: no output register, zero latency.
- The first word is valid after WORD_BITS adv edges. Adv edges are counted from the first edge with rst=0 and en=1.
- Throughput is one word per WORD_BITS cycles when en=1 and word_ready=1, with no bubbles. A complete-and-accept on the same edge does not stall.
- Load takes effect at the next edge. The new out is visible in the following cycle.
- With defaults the state sequence from 0xAA is AA, 55, AB, 57, AF, 5F, BE, 7C, F9.
- Because of the left shift, the first WIDTH out bits always equal the starting state, MSB first.

## Test plan
- Reset plus free run with defaults, en=1, word_ready=1:
  - out sequence 1,0,1,0,1,0,1,0 over the first 8 cycles;
  - word_valid rises after the 8th edge with word_data=0xAA;
  - the next word is 0xF9.
- Backpressure: hold word_ready=0 after the first word.
  - word_valid stays 1, word_data stays 0xAA, out stays at the MSB of 0xF9 (1).
  - Release word_ready: the stream resumes with no lost or duplicated bits, and the second word is 0xF9.
- Seed load of 0x3C mid-word, after 3 adv edges:
  - the partial word is discarded;
  - the next word is 0x3C;
  - seed_fixed stays 0.
- Zero seed: load=1, seed=0.
  - seed_fixed pulses for exactly 1 cycle;
  - state becomes 0xAA, and the next word is 0xAA.
- Reset asserted mid-word, and separately while word_valid=1 and word_ready=0:
  - after the edge, word_valid=0, word_data=0, state=0xAA;
  - then the default sequence repeats.
- Non-default parameters WIDTH=16, TAPS=16'hB400, WORD_BITS=4, RESET_VALUE=16'h0001, run for 65535 adv edges:
  - state returns to 0x0001 exactly at edge 65535 and never earlier;
  - state is never 0.

Source files
------------

// File: rtl/tausworthe_gen_if.sv
// Word stream carrying packed LFSR bits from the generator to its consumer.
// word_data is held stable while word_valid=1 and word_ready=0.
interface tausworthe_gen_if #(
  parameter int WORD_BITS = 8
) ();
  logic [WORD_BITS-1:0] word_data;
  logic                 word_valid;
  logic                 word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/tausworthe_gen.sv
// Fibonacci LFSR (left shift, MSB is the serial output) with zero-safe seed
// loading and packing of WORD_BITS bits per word onto a valid/ready stream.
module tausworthe_gen #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'b10111000,
  parameter logic [WIDTH-1:0] RESET_VALUE = 8'b10101010,
  parameter int               WORD_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [WIDTH-1:0]        seed,
  output logic                    out,
  output logic                    seed_fixed,
  tausworthe_gen_if.master        word
);

  localparam int               CNT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

  generate
    if (WIDTH < 2)            $error("tausworthe_gen: WIDTH must be at least 2");
    if (WORD_BITS < 1)        $error("tausworthe_gen: WORD_BITS must be at least 1");
    if (TAPS[WIDTH-1] != 1'b1) $error("tausworthe_gen: TAPS MSB must be set");
    if (RESET_VALUE == '0)    $error("tausworthe_gen: RESET_VALUE must be non-zero");
  endgenerate

  function automatic logic parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // An all-zero state would lock the LFSR, so it is swapped for the reset value.
  function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? RESET_VALUE : s;
  endfunction

  // Widened so that WORD_BITS=1 needs no special case.
  function automatic logic [WORD_BITS-1:0] shift_in(input logic [WORD_BITS-1:0] s,
                                                     input logic               b);
    logic [WORD_BITS:0] t;
    t = {s, b};
    return t[WORD_BITS-1:0];
  endfunction

  logic [WIDTH-1:0]     state_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic [WORD_BITS-1:0] shreg_p0;
  logic [WORD_BITS-1:0] word_p1;
  logic                 vld_p1;
  logic                 fixed_p1;

  logic                 fb;
  logic                 adv;
  logic                 consume;
  logic                 last;
  logic [WORD_BITS-1:0] packed_word;

  always_comb begin
    fb          = parity(state_p0 & TAPS);
    adv         = en & ~load & (~vld_p1 | word.word_ready);
    consume     = vld_p1 & word.word_ready;
    last        = (cnt_p0 == CNT_LAST);
    packed_word = shift_in(shreg_p0, state_p0[WIDTH-1]);
  end

  // Stage p0: generator state, bit counter and partial-word shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= RESET_VALUE;
      cnt_p0   <= '0;
      shreg_p0 <= '0;
    end else if (load) begin
      state_p0 <= fix_seed(seed);
      cnt_p0   <= '0;
      shreg_p0 <= '0;
    end else if (adv) begin
      state_p0 <= {state_p0[WIDTH-2:0], fb};
      shreg_p0 <= packed_word;
      cnt_p0   <= last ? '0 : cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: completed word register, valid flag and zero-seed pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      word_p1  <= '0;
      vld_p1   <= 1'b0;
      fixed_p1 <= 1'b0;
    end else begin
      fixed_p1 <= load & (seed == '0);
      if (adv && last) begin
        word_p1 <= packed_word;
        vld_p1  <= 1'b1;
      end else if (consume) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out             = state_p0[WIDTH-1];
  assign seed_fixed      = fixed_p1;
  assign word.word_data  = word_p1;
  assign word.word_valid = vld_p1;

endmodule

// File: tb/tb_tausworthe_gen.sv
// Bench for tausworthe_gen: directed scenarios plus random traffic against a
// queue-based model, and a full-period run of a 16-bit configuration.
module tb_tausworthe_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, out, seed_fixed;
  logic [7:0] seed;
  tausworthe_gen_if #(.WORD_BITS(8)) wif ();

  tausworthe_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seed       (seed),
    .out        (out),
    .seed_fixed (seed_fixed),
    .word       (wif)
  );

  logic        rst2, en2, load2, out2, fixed2;
  logic [15:0] seed2;
  tausworthe_gen_if #(.WORD_BITS(4)) wif2 ();

  tausworthe_gen #(
    .WIDTH       (16),
    .TAPS        (16'hB400),
    .RESET_VALUE (16'h0001),
    .WORD_BITS   (4)
  ) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .en         (en2),
    .load       (load2),
    .seed       (seed2),
    .out        (out2),
    .seed_fixed (fixed2),
    .word       (wif2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model for the default configuration
  int m_state;
  bit m_bits[$];
  bit m_valid;
  int m_data;
  bit m_fixed;

  function automatic int lfsr_next(int s, int taps, int w);
    int fb;
    fb = $countones(s & taps) % 2;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  task automatic model_step(bit r, bit e, bit l, int sd, bit rd);
    bit consume, adv;
    if (r) begin
      m_state = 'hAA;
      m_bits.delete();
      m_valid = 0;
      m_data  = 0;
      m_fixed = 0;
    end else begin
      consume = m_valid && rd;
      adv     = e && !l && (!m_valid || rd);
      m_fixed = l && (sd == 0);
      if (l) begin
        m_state = (sd == 0) ? 'hAA : sd;
        m_bits.delete();
        if (consume) m_valid = 0;
      end else if (adv) begin
        m_bits.push_back(m_state[7]);
        m_state = lfsr_next(m_state, 'hB8, 8);
        if (m_bits.size() == 8) begin
          m_data = 0;
          foreach (m_bits[i]) m_data = (m_data << 1) | int'(m_bits[i]);
          m_bits.delete();
          m_valid = 1;
        end else if (consume) begin
          m_valid = 0;
        end
      end else if (consume) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(bit r, bit e, bit l, logic [7:0] sd, bit rd);
    rst = r; en = e; load = l; seed = sd; wif.word_ready = rd;
    @(posedge clk);
    model_step(r, e, l, int'(sd), rd);
    #1;
    check("cycle", {21'd0, out, wif.word_valid, wif.word_data, seed_fixed},
          {21'd0, m_state[7], m_valid, m_data[7:0], m_fixed});
  endtask

  logic [7:0]  seq;
  logic [15:0] win;
  int          first_one, zero_seen, start_state, mism2, m2;

  initial begin
    rst = 1; en = 0; load = 0; seed = '0; wif.word_ready = 0;
    rst2 = 1; en2 = 0; load2 = 0; seed2 = '0; wif2.word_ready = 0;

    // Reset state and free run with defaults
    tick(1, 0, 0, 8'h00, 0);
    check("reset", {out, wif.word_valid, wif.word_data, seed_fixed}, {1'b1, 1'b0, 8'h00, 1'b0});
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], out};
      tick(0, 1, 0, 8'h00, 1);
    end
    check("out_seq", seq, 8'hAA);
    check("word1", {wif.word_valid, wif.word_data}, {1'b1, 8'hAA});
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    check("word2", {wif.word_valid, wif.word_data}, {1'b1, 8'hF9});

    // Backpressure after the first word
    tick(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 8'h00, 0);
    check("bp_hold", {wif.word_valid, wif.word_data, out}, {1'b1, 8'hAA, 1'b1});
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    check("bp_resume", {wif.word_valid, wif.word_data}, {1'b1, 8'hF9});

    // Seed load mid-word
    tick(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00, 1);
    tick(0, 1, 1, 8'h3C, 1);
    check("load_nofix", seed_fixed, 1'b0);
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    check("load_word", {wif.word_valid, wif.word_data}, {1'b1, 8'h3C});

    // Zero seed replaced by the reset value
    tick(0, 1, 1, 8'h00, 1);
    check("zfix_pulse", seed_fixed, 1'b1);
    tick(0, 1, 0, 8'h00, 1);
    check("zfix_clear", seed_fixed, 1'b0);
    for (int i = 0; i < 7; i++) tick(0, 1, 0, 8'h00, 1);
    check("zfix_word", {wif.word_valid, wif.word_data}, {1'b1, 8'hAA});

    // Reset mid-word, then while a word is stalled
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00, 1);
    tick(1, 1, 0, 8'h00, 1);
    check("rst_mid", {wif.word_valid, wif.word_data, out}, {1'b0, 8'h00, 1'b1});
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], out};
      tick(0, 1, 0, 8'h00, 1);
    end
    check("rst_seq", seq, 8'hAA);
    tick(0, 1, 0, 8'h00, 0);
    tick(0, 1, 0, 8'h00, 0);
    tick(1, 1, 0, 8'h00, 0);
    check("rst_stall", {wif.word_valid, wif.word_data, out}, {1'b0, 8'h00, 1'b1});
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    check("rst_word1", {wif.word_valid, wif.word_data}, {1'b1, 8'hAA});
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'h00, 1);
    check("rst_word2", {wif.word_valid, wif.word_data}, {1'b1, 8'hF9});

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
           ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(9) < 6);
    end

    // Full period of the 16-bit configuration, observed through out2
    rst = 1; en = 0;
    @(posedge clk);
    #1;
    rst2 = 0; en2 = 1; wif2.word_ready = 1;
    m2 = 1; win = '0; first_one = 0; zero_seen = 0; start_state = 0; mism2 = 0;
    for (int j = 0; j <= 65550; j++) begin
      if (out2 !== m2[15]) mism2++;
      win = {win[14:0], out2};
      if (j >= 15) begin
        if (win == 16'h0000) zero_seen++;
        if (j == 15) start_state = int'(win);
        else if (win == 16'h0001 && first_one == 0) first_one = j - 15;
      end
      if (j == 4)  check("w16_word1", {wif2.word_valid, wif2.word_data}, {1'b1, 4'h0});
      if (j == 16) check("w16_word4", {wif2.word_valid, wif2.word_data}, {1'b1, 4'h1});
      @(posedge clk);
      #1;
      m2 = lfsr_next(m2, 'hB400, 16);
    end
    check("w16_start", start_state, 1);
    check("w16_period", first_one, 65535);
    check("w16_nonzero", zero_seen, 0);
    check("w16_out_model", mism2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
